pll_lock_sequencer: RTL
=======================

Name: pll_lock_sequencer

Overview:
Power-up and recovery sequencer for the on-chip PLLVR clock generator (25 MHz in, single CLKOUT plus LOCK).
- Holds the PLL in reset for a programmed time, then waits for LOCK with a timeout and retries on failure.
- Requires LOCK to stay stable before releasing the downstream system reset.
- Re-runs the sequence on loss of lock or on software request, and latches a fault after repeated failures.
- Runs entirely in the clkin (reference) domain. Downstream logic re-synchronises sys_rst into the clkout domain.

Parameters:
- RST_CYCLES, 16: clkin cycles pll_reset is held high per attempt (>=1).
- LOCK_TIMEOUT, 25000: clkin cycles allowed in WAIT_LOCK per attempt (1 ms at 25 MHz).
- STABLE_CYCLES, 256: consecutive synchronised-lock-high cycles required before RUN.
- MAX_RETRIES, 3: failed attempts (timeouts) tolerated before FAULT (>=1).
- CNT_W, 16: shared cycle counter width; must hold max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES).

Ports:
- clkin, input, 1: reference clock, free-running, same net as the PLL input.
- reset, input, 1: synchronous, active-high reset.
- pll_lock, input, 1: PLL LOCK output; asynchronous to clkin.
- restart, input, 1: single-cycle request to re-run the sequence from RESET_PLL.
- pll_reset, output, 1: drives the PLL RESET pin; active-high.
- sys_rst, output, 1: active-high reset for logic clocked by the PLL output.
- ready, output, 1: high only in RUN.
- fault, output, 1: high only in FAULT.
- retry_cnt, output, 2: failed attempts in the current sequence; saturates at 3.
- state_o, output, 3: current state encoding, for debug.
- loss_cnt, output, 8: lock-loss events while in RUN (see Optional Feature).

Behaviour:
- pll_lock passes through a 2-FF synchroniser to give lock_s. Both FFs clear to 0 on reset.
- All outputs are decoded from registered state, so they change on the same edge as the state change.
- Reset values: state=RESET_PLL, counter=0, pll_reset=1, sys_rst=1, ready=0, fault=0, retry_cnt=0, loss_cnt=0, sync FFs=0.
- State encodings: RESET_PLL=0, WAIT_LOCK=1, STABILIZE=2, RUN=3, FAULT=4.
- Output table:
  - RESET_PLL: pll_reset=1, sys_rst=1.
  - WAIT_LOCK and STABILIZE: pll_reset=0, sys_rst=1.
  - RUN: pll_reset=0, sys_rst=0, ready=1.
  - FAULT: pll_reset=1, sys_rst=1, fault=1.
- RESET_PLL:
  - Counter increments each cycle.
  - When counter==RST_CYCLES-1, go to WAIT_LOCK with counter=0.
  - pll_reset is therefore high for exactly RST_CYCLES cycles after reset deasserts.
- WAIT_LOCK:
  - Counter increments each cycle.
  - If lock_s=1, go to STABILIZE with counter=0. This has priority over timeout.
  - Else, if counter==LOCK_TIMEOUT-1: if retry_cnt+1 >= MAX_RETRIES go to FAULT; otherwise go to RESET_PLL. Both paths increment retry_cnt (saturating) and clear the counter.
- STABILIZE:
  - If lock_s=0, go to WAIT_LOCK with counter=0. This is a glitch, not a retry, so retry_cnt is unchanged.
  - Else, if counter==STABLE_CYCLES-1, go to RUN and clear retry_cnt. Otherwise increment the counter.
- RUN: if lock_s=0, go to RESET_PLL with counter=0 and increment loss_cnt (saturating at 255).
- FAULT: terminal. Left only by reset or restart.
- restart=1 in any state: next state is RESET_PLL with counter=0 and retry_cnt=0. This has priority over every other transition; loss_cnt is unchanged.
- Latency: ready rises STABLE_CYCLES+2 clkin edges after the first edge that samples pll_lock high while in WAIT_LOCK (2 synchroniser edges plus 1 detect edge, minus overlap).
- Reset asserted mid-sequence: on the next edge, all state returns to the reset values; the PLL is re-reset.

Optional Feature:
- Macro: PLLSEQ_LOSS_CNT_EN.
- Defined: loss_cnt is an 8-bit saturating counter. It increments once per RUN to RESET_PLL transition caused by lock_s=0, and clears only on reset.
- Undefined: the counter is not built and the loss_cnt port is tied to 8'd0. The port list does not change.

Test Plan:
Test parameters: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.
- Nominal bring-up: release reset, raise pll_lock 10 cycles later and hold it. Expect pll_reset high for exactly 4 cycles, ready and sys_rst=0 exactly 10 edges after the first sampled lock, and retry_cnt=0.
- No lock: hold pll_lock=0. Expect two WAIT_LOCK windows of 20 cycles each, separated by a 4-cycle pll_reset pulse. After the second timeout expect fault=1, pll_reset=1, retry_cnt=2, and the state held indefinitely.
- Stabilise glitch: drop pll_lock for 3 cycles midway through STABILIZE. Expect a return to WAIT_LOCK with retry_cnt unchanged, then RUN 8 stable cycles after lock_s returns.
- Loss in RUN: drop pll_lock for 1 cycle while in RUN. Expect sys_rst=1 and pll_reset=1 within 3 edges, the full sequence re-run, and loss_cnt=1 (0 with the macro undefined).
- Restart out of FAULT: pulse restart once while in FAULT. Expect RESET_PLL on the next edge, fault=0, retry_cnt=0, then nominal bring-up once pll_lock is supplied.
- Reset mid-STABILIZE: assert reset for 1 cycle. Expect all outputs at their reset values on the next edge, then pll_reset held for 4 cycles.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// PLL power-up/recovery sequencer running in the clkin domain.
// Define PLLSEQ_LOSS_CNT_EN to build the saturating lock-loss counter behind loss_cnt.
module pll_lock_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 25000,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 16
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       restart,
  output logic       pll_reset,
  output logic       sys_rst,
  output logic       ready,
  output logic       fault,
  output logic [1:0] retry_cnt,
  output logic [2:0] state_o,
  output logic [7:0] loss_cnt
);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic [1:0]       retry_nxt;
  logic             sync_1;
  logic             lock_s;
  logic             last_try;

  // pll_lock is asynchronous to clkin, so it only enters the FSM through lock_s.
  always_ff @(posedge clkin) begin
    if (reset) begin
      sync_1 <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync_1 <= pll_lock;
      lock_s <= sync_1;
    end
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state     <= RESET_PLL;
      count     <= '0;
      retry_cnt <= 2'd0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      retry_cnt <= retry_nxt;
    end
  end

  assign last_try = (int'(retry_cnt) + 1) >= MAX_RETRIES;

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    retry_nxt = retry_cnt;
    if (restart) begin
      state_nxt = RESET_PLL;
      count_nxt = '0;
      retry_nxt = 2'd0;
    end else begin
      case (state)
        RESET_PLL: begin
          if (count == RST_LAST) begin
            state_nxt = WAIT_LOCK;
            count_nxt = '0;
          end else begin
            count_nxt = count + CNT_ONE;
          end
        end
        WAIT_LOCK: begin
          // A lock seen on the final timeout cycle still wins over the retry.
          if (lock_s) begin
            state_nxt = STABILIZE;
            count_nxt = '0;
          end else if (count == TIMEOUT_LAST) begin
            state_nxt = last_try ? FAULT : RESET_PLL;
            count_nxt = '0;
            retry_nxt = (retry_cnt == 2'd3) ? 2'd3 : retry_cnt + 2'd1;
          end else begin
            count_nxt = count + CNT_ONE;
          end
        end
        STABILIZE: begin
          if (!lock_s) begin
            state_nxt = WAIT_LOCK;
            count_nxt = '0;
          end else if (count == STABLE_LAST) begin
            state_nxt = RUN;
            count_nxt = '0;
            retry_nxt = 2'd0;
          end else begin
            count_nxt = count + CNT_ONE;
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_nxt = RESET_PLL;
            count_nxt = '0;
          end
        end
        FAULT: begin
          state_nxt = FAULT;
        end
        default: begin
          state_nxt = RESET_PLL;
          count_nxt = '0;
        end
      endcase
    end
  end

  always_comb begin
    pll_reset = 1'b1;
    sys_rst   = 1'b1;
    ready     = 1'b0;
    fault     = 1'b0;
    case (state)
      WAIT_LOCK, STABILIZE: begin
        pll_reset = 1'b0;
      end
      RUN: begin
        pll_reset = 1'b0;
        sys_rst   = 1'b0;
        ready     = 1'b1;
      end
      FAULT: begin
        fault = 1'b1;
      end
      default: begin
        pll_reset = 1'b1;
      end
    endcase
  end

  assign state_o = state;

`ifdef PLLSEQ_LOSS_CNT_EN
  logic       lock_lost;
  logic [7:0] loss_q;

  // Only a genuine drop of lock in RUN counts; a restart in RUN does not.
  assign lock_lost = (state == RUN) && !lock_s && !restart;

  always_ff @(posedge clkin) begin
    if (reset) begin
      loss_q <= 8'd0;
    end else if (lock_lost && (loss_q != 8'hFF)) begin
      loss_q <= loss_q + 8'd1;
    end
  end

  assign loss_cnt = loss_q;
`else
  assign loss_cnt = 8'd0;
`endif

endmodule
